// File: rtl/ahblite_burst_master_if.sv
// Front-end command/write/read handshakes plus the AHB-Lite initiator bus, bundled for one burst master.
interface ahblite_burst_master_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic [31:0]      wr_data;
  logic             wr_ready;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic             done;
  logic             done_err;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [3:0]       HPROT;
  logic [31:0]      HWDATA;
  logic             HREADY;
  logic             HRESP;
  logic [31:0]      HRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
    input  HREADY, HRESP, HRDATA,
    output cmd_ready, wr_ready, rd_valid, rd_data, done, done_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data,
    output HREADY, HRESP, HRDATA,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done, done_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahblite_burst_master.sv
// AHB-Lite INCR burst initiator: one command -> len+1 word beats, split at 1 KB, aborted on ERROR.
// Latency: first address phase the cycle after cmd accept; done pulses one cycle after the final data phase. No read backpressure; writes stall with BUSY.
module ahblite_burst_master #(
  parameter int         LEN_W     = 8,
  parameter logic [3:0] HPROT_VAL = 4'h3
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahblite_burst_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAST, S_ERR, S_DONE} state_t;

  localparam logic [1:0]   T_IDLE   = 2'b00;
  localparam logic [1:0]   T_BUSY   = 2'b01;
  localparam logic [1:0]   T_NONSEQ = 2'b10;
  localparam logic [1:0]   T_SEQ    = 2'b11;
  localparam logic [LEN_W:0] ONE    = {{LEN_W{1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_haddr;
  logic [31:0]      r_hwdata;
  logic [31:0]      r_rd_data;
  logic             r_hwrite;
  logic             r_first;
  logic             r_locked;
  logic             r_dphase;
  logic             r_dwr;
  logic             r_err;
  logic             r_rd_valid;
  logic [LEN_W:0]   r_remain;

  logic [31:0]      w_next_addr;
  logic [1:0]       w_htrans;
  logic [1:0]       w_htrans_out;
  logic             w_go;
  logic             w_acc;
  logic             w_err1;
  logic             w_cmd_acc;
  logic             w_last_beat;
  logic             w_cmd_ready;
  logic             w_done;
  logic             w_done_err;
  logic             w_unused;

  assign w_next_addr = r_haddr + 32'd4;
  assign w_cmd_acc   = bus.cmd_valid && (r_state == S_IDLE);
  // Once a write beat sits in a stalled address phase it must stay presented.
  assign w_go        = !r_hwrite || bus.wr_valid || r_locked;
  assign w_err1      = r_dphase && bus.HRESP && !bus.HREADY;
  assign w_acc       = (r_state == S_ADDR) && bus.HREADY && w_htrans[1];
  assign w_last_beat = (r_remain == ONE);
  assign w_unused    = ^bus.cmd_addr[1:0];

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.cmd_valid) w_next = S_ADDR;
      S_ADDR: begin
        if (w_err1)                    w_next = S_ERR;
        else if (w_acc && w_last_beat) w_next = S_LAST;
      end
      S_LAST: begin
        if (w_err1)           w_next = S_ERR;
        else if (bus.HREADY)  w_next = S_DONE;
      end
      S_ERR:  if (bus.HREADY) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_htrans    = T_IDLE;
    w_cmd_ready = 1'b0;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      S_IDLE: w_cmd_ready = 1'b1;
      S_ADDR: begin
        if (r_first) w_htrans = w_go ? T_NONSEQ : T_IDLE;
        else         w_htrans = w_go ? T_SEQ : T_BUSY;
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_done_err = r_err;
      end
      default: w_htrans = T_IDLE;
    endcase
    // First ERROR cycle: withdraw whatever address phase is on the bus.
    w_htrans_out = w_err1 ? T_IDLE : w_htrans;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_haddr    <= 32'd0;
      r_hwdata   <= 32'd0;
      r_rd_data  <= 32'd0;
      r_hwrite   <= 1'b0;
      r_first    <= 1'b1;
      r_locked   <= 1'b0;
      r_dphase   <= 1'b0;
      r_dwr      <= 1'b0;
      r_err      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_remain   <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_locked   <= (r_state == S_ADDR) && w_htrans[1] && !bus.HREADY && !w_err1;
      if (w_cmd_acc) begin
        r_haddr  <= {bus.cmd_addr[31:2], 2'b00};
        r_hwrite <= bus.cmd_write;
        r_remain <= {1'b0, bus.cmd_len} + ONE;
        r_first  <= 1'b1;
        r_err    <= 1'b0;
      end
      if (w_acc) begin
        r_haddr  <= w_next_addr;
        r_first  <= (w_next_addr[9:0] == 10'd0);
        r_remain <= r_remain - ONE;
        if (r_hwrite) r_hwdata <= bus.wr_data;
      end
      if (bus.HREADY) begin
        r_dphase <= w_acc;
        r_dwr    <= r_hwrite;
        if (r_dphase && !r_dwr && !bus.HRESP) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= bus.HRDATA;
        end
      end
      if (w_err1) begin
        r_dphase <= 1'b0;
        r_err    <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.wr_ready  = w_acc && r_hwrite;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.done      = w_done;
  assign bus.done_err  = w_done_err;
  assign bus.HADDR     = r_haddr;
  assign bus.HTRANS    = w_htrans_out;
  assign bus.HWRITE    = r_hwrite;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b001;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_ahblite_burst_master.sv
// Directed bench for ahblite_burst_master: the bench plays the AHB slave and the front end cycle by cycle.
module tb_ahblite_burst_master;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_beats, n_nonseq, n_rdv;
  logic seen_done;

  ahblite_burst_master_if #(.LEN_W(8)) bus ();

  ahblite_burst_master #(.LEN_W(8), .HPROT_VAL(4'h3)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: inputs applied just after the rising edge, outputs sampled on the falling edge.
  task automatic drv(input logic cv, input logic wv, input logic [31:0] wd,
                     input logic rdy, input logic resp, input logic [31:0] rd);
    @(posedge HCLK);
    #1;
    bus.cmd_valid = cv;
    bus.wr_valid  = wv;
    bus.wr_data   = wd;
    bus.HREADY    = rdy;
    bus.HRESP     = resp;
    bus.HRDATA    = rd;
    @(negedge HCLK);
  endtask

  task automatic cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, required completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0; bus.cmd_len = 8'd0;
    bus.wr_valid = 1'b0;  bus.wr_data = 32'd0;  bus.HREADY = 1'b1;    bus.HRESP = 1'b0;
    bus.HRDATA = 32'd0;

    // Reset state
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("rst_htrans",    bus.HTRANS,    TI);
    chk32("rst_haddr",     bus.HADDR,     32'h0);
    chk1 ("rst_hwrite",    bus.HWRITE,    1'b0);
    chk32("rst_hwdata",    bus.HWDATA,    32'h0);
    chk1 ("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1 ("rst_wr_ready",  bus.wr_ready,  1'b0);
    chk1 ("rst_rd_valid",  bus.rd_valid,  1'b0);
    chk1 ("rst_done",      bus.done,      1'b0);
    chk1 ("rst_done_err",  bus.done_err,  1'b0);
    chk32("rst_hsize",     32'(bus.HSIZE),  32'h2);
    chk32("rst_hburst",    32'(bus.HBURST), 32'h1);
    chk32("rst_hprot",     32'(bus.HPROT),  32'h3);
    HRESET = 1'b0;
    drv(0, 0, 0, 1, 0, 0);

    // T1: single read at 0x40
    cmd(0, 32'h40, 8'd0);
    drv(1, 0, 0, 1, 0, 0);
    chk1 ("t1_cmd_ready", bus.cmd_ready, 1'b1);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t1_htrans",    bus.HTRANS, TN);
    chk32("t1_haddr",     bus.HADDR,  32'h40);
    chk1 ("t1_hwrite",    bus.HWRITE, 1'b0);
    chk1 ("t1_busy_rdy",  bus.cmd_ready, 1'b0);
    drv(0, 0, 0, 1, 0, 32'h0032_0000);
    chk2 ("t1_last_htrans", bus.HTRANS, TI);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t1_rd_valid",  bus.rd_valid, 1'b1);
    chk32("t1_rd_data",   bus.rd_data,  32'h0032_0000);
    chk1 ("t1_done",      bus.done,     1'b1);
    chk1 ("t1_done_err",  bus.done_err, 1'b0);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t1_ready_after", bus.cmd_ready, 1'b1);
    chk1 ("t1_done_pulse",  bus.done,      1'b0);

    // T2: 4-beat write, 2 wait states in beat 2 data phase
    cmd(1, 32'h0, 8'd3);
    drv(1, 1, 32'd1, 1, 0, 0);
    drv(0, 1, 32'd1, 1, 0, 0);
    chk2 ("t2_b1_htrans", bus.HTRANS, TN);
    chk32("t2_b1_haddr",  bus.HADDR,  32'h0);
    chk1 ("t2_b1_hwrite", bus.HWRITE, 1'b1);
    chk1 ("t2_b1_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 1, 32'd2, 1, 0, 0);
    chk2 ("t2_b2_htrans", bus.HTRANS, TS);
    chk32("t2_b2_haddr",  bus.HADDR,  32'h4);
    chk32("t2_b2_hwdata", bus.HWDATA, 32'd1);
    chk1 ("t2_b2_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 1, 32'd3, 0, 0, 0);
    chk2 ("t2_ws1_htrans", bus.HTRANS, TS);
    chk32("t2_ws1_haddr",  bus.HADDR,  32'h8);
    chk32("t2_ws1_hwdata", bus.HWDATA, 32'd2);
    chk1 ("t2_ws1_wrrdy",  bus.wr_ready, 1'b0);
    drv(0, 1, 32'd3, 0, 0, 0);
    chk32("t2_ws2_haddr",  bus.HADDR,  32'h8);
    chk32("t2_ws2_hwdata", bus.HWDATA, 32'd2);
    chk1 ("t2_ws2_wrrdy",  bus.wr_ready, 1'b0);
    drv(0, 1, 32'd3, 1, 0, 0);
    chk2 ("t2_b3_htrans", bus.HTRANS, TS);
    chk32("t2_b3_haddr",  bus.HADDR,  32'h8);
    chk32("t2_b3_hwdata", bus.HWDATA, 32'd2);
    chk1 ("t2_b3_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 1, 32'd4, 1, 0, 0);
    chk2 ("t2_b4_htrans", bus.HTRANS, TS);
    chk32("t2_b4_haddr",  bus.HADDR,  32'hC);
    chk32("t2_b4_hwdata", bus.HWDATA, 32'd3);
    chk1 ("t2_b4_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 0, 32'd0, 1, 0, 0);
    chk2 ("t2_last_htrans", bus.HTRANS, TI);
    chk32("t2_last_hwdata", bus.HWDATA, 32'd4);
    chk1 ("t2_last_wrrdy",  bus.wr_ready, 1'b0);
    drv(0, 0, 32'd0, 1, 0, 0);
    chk1 ("t2_done",     bus.done,     1'b1);
    chk1 ("t2_done_err", bus.done_err, 1'b0);

    // T3: 3-beat write, front end stalls 3 cycles before beat 2
    cmd(1, 32'h100, 8'd2);
    drv(1, 1, 32'hA1, 1, 0, 0);
    drv(0, 1, 32'hA1, 1, 0, 0);
    chk2 ("t3_b1_htrans", bus.HTRANS, TN);
    chk32("t3_b1_haddr",  bus.HADDR,  32'h100);
    chk1 ("t3_b1_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 0, 32'h0, 1, 0, 0);
    chk2 ("t3_busy1_htrans", bus.HTRANS, TB);
    chk32("t3_busy1_haddr",  bus.HADDR,  32'h104);
    chk1 ("t3_busy1_wrrdy",  bus.wr_ready, 1'b0);
    drv(0, 0, 32'h0, 1, 0, 0);
    chk2 ("t3_busy2_htrans", bus.HTRANS, TB);
    drv(0, 0, 32'h0, 1, 0, 0);
    chk2 ("t3_busy3_htrans", bus.HTRANS, TB);
    chk32("t3_busy3_haddr",  bus.HADDR,  32'h104);
    drv(0, 1, 32'hA2, 1, 0, 0);
    chk2 ("t3_b2_htrans", bus.HTRANS, TS);
    chk32("t3_b2_haddr",  bus.HADDR,  32'h104);
    chk32("t3_b2_hwdata", bus.HWDATA, 32'hA1);
    chk1 ("t3_b2_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 1, 32'hA3, 1, 0, 0);
    chk2 ("t3_b3_htrans", bus.HTRANS, TS);
    chk32("t3_b3_haddr",  bus.HADDR,  32'h108);
    chk32("t3_b3_hwdata", bus.HWDATA, 32'hA2);
    chk1 ("t3_b3_wrrdy",  bus.wr_ready, 1'b1);
    drv(0, 0, 32'h0, 1, 0, 0);
    chk2 ("t3_last_htrans", bus.HTRANS, TI);
    chk32("t3_last_hwdata", bus.HWDATA, 32'hA3);
    drv(0, 0, 32'h0, 1, 0, 0);
    chk1 ("t3_done", bus.done, 1'b1);

    // T4: read across the 1 KB boundary
    cmd(0, 32'h3F8, 8'd3);
    drv(1, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t4_b1_htrans", bus.HTRANS, TN);
    chk32("t4_b1_haddr",  bus.HADDR,  32'h3F8);
    drv(0, 0, 0, 1, 0, 32'hD1);
    chk2 ("t4_b2_htrans", bus.HTRANS, TS);
    chk32("t4_b2_haddr",  bus.HADDR,  32'h3FC);
    drv(0, 0, 0, 1, 0, 32'hD2);
    chk2 ("t4_b3_htrans", bus.HTRANS, TN);
    chk32("t4_b3_haddr",  bus.HADDR,  32'h400);
    chk1 ("t4_rv1",       bus.rd_valid, 1'b1);
    chk32("t4_rd1",       bus.rd_data,  32'hD1);
    drv(0, 0, 0, 1, 0, 32'hD3);
    chk2 ("t4_b4_htrans", bus.HTRANS, TS);
    chk32("t4_b4_haddr",  bus.HADDR,  32'h404);
    chk32("t4_rd2",       bus.rd_data,  32'hD2);
    drv(0, 0, 0, 1, 0, 32'hD4);
    chk2 ("t4_last_htrans", bus.HTRANS, TI);
    chk1 ("t4_rv3",       bus.rd_valid, 1'b1);
    chk32("t4_rd3",       bus.rd_data,  32'hD3);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t4_done",      bus.done,     1'b1);
    chk1 ("t4_rv4",       bus.rd_valid, 1'b1);
    chk32("t4_rd4",       bus.rd_data,  32'hD4);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t4_rv_end",    bus.rd_valid, 1'b0);

    // T5: ERROR on beat 2 of a 6-beat read
    cmd(0, 32'h200, 8'd5);
    drv(1, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t5_b1_htrans", bus.HTRANS, TN);
    chk32("t5_b1_haddr",  bus.HADDR,  32'h200);
    drv(0, 0, 0, 1, 0, 32'hE1);
    chk2 ("t5_b2_htrans", bus.HTRANS, TS);
    chk32("t5_b2_haddr",  bus.HADDR,  32'h204);
    drv(0, 0, 0, 0, 1, 32'hBAD0);
    chk2 ("t5_cancel_htrans", bus.HTRANS, TI);
    chk1 ("t5_rv1",        bus.rd_valid, 1'b1);
    chk32("t5_rd1",        bus.rd_data,  32'hE1);
    chk1 ("t5_err1_done",  bus.done,     1'b0);
    drv(0, 0, 0, 1, 1, 32'hBAD1);
    chk2 ("t5_err2_htrans", bus.HTRANS, TI);
    chk1 ("t5_err2_rv",     bus.rd_valid, 1'b0);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t5_done",     bus.done,     1'b1);
    chk1 ("t5_done_err", bus.done_err, 1'b1);
    chk1 ("t5_done_rv",  bus.rd_valid, 1'b0);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t5_ready",    bus.cmd_ready, 1'b1);

    // T6: reset in the middle of an 8-beat write, then a clean read
    cmd(1, 32'h500, 8'd7);
    drv(1, 1, 32'hB0, 1, 0, 0);
    drv(0, 1, 32'hB0, 1, 0, 0);
    chk2 ("t6_b1_htrans", bus.HTRANS, TN);
    drv(0, 1, 32'hB1, 1, 0, 0);
    chk32("t6_b2_haddr",  bus.HADDR, 32'h504);
    drv(0, 1, 32'hB2, 1, 0, 0);
    chk32("t6_b3_haddr",  bus.HADDR, 32'h508);
    HRESET = 1'b1;
    drv(0, 1, 32'hB3, 1, 0, 0);
    chk2 ("t6_rst_htrans", bus.HTRANS,    TI);
    chk1 ("t6_rst_ready",  bus.cmd_ready, 1'b1);
    chk1 ("t6_rst_done",   bus.done,      1'b0);
    chk1 ("t6_rst_wrrdy",  bus.wr_ready,  1'b0);
    HRESET = 1'b0;
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t6_no_done",   bus.done,      1'b0);
    chk1 ("t6_idle_rdy",  bus.cmd_ready, 1'b1);
    cmd(0, 32'h80, 8'd1);
    drv(1, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t6_n1_htrans", bus.HTRANS, TN);
    chk32("t6_n1_haddr",  bus.HADDR,  32'h80);
    drv(0, 0, 0, 1, 0, 32'hF1);
    chk2 ("t6_n2_htrans", bus.HTRANS, TS);
    chk32("t6_n2_haddr",  bus.HADDR,  32'h84);
    drv(0, 0, 0, 1, 0, 32'hF2);
    chk32("t6_rd1",       bus.rd_data,  32'hF1);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t6_done",      bus.done,     1'b1);
    chk1 ("t6_done_err",  bus.done_err, 1'b0);
    chk32("t6_rd2",       bus.rd_data,  32'hF2);

    // T7: address wrap at the top of the map is also a segment split
    cmd(0, 32'hFFFF_FFF8, 8'd3);
    drv(1, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t7_b1_htrans", bus.HTRANS, TN);
    chk32("t7_b1_haddr",  bus.HADDR,  32'hFFFF_FFF8);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t7_b2_htrans", bus.HTRANS, TS);
    chk32("t7_b2_haddr",  bus.HADDR,  32'hFFFF_FFFC);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t7_b3_htrans", bus.HTRANS, TN);
    chk32("t7_b3_haddr",  bus.HADDR,  32'h0);
    drv(0, 0, 0, 1, 0, 0);
    chk2 ("t7_b4_htrans", bus.HTRANS, TS);
    chk32("t7_b4_haddr",  bus.HADDR,  32'h4);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk1 ("t7_done",      bus.done, 1'b1);

    // T8: maximum length (256 beats) filling exactly one 1 KB segment
    cmd(0, 32'h1000, 8'hFF);
    drv(1, 0, 0, 1, 0, 0);
    n_beats = 0; n_nonseq = 0; n_rdv = 0; seen_done = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      drv(0, 0, 0, 1, 0, 32'(i));
      if (bus.HTRANS[1])      n_beats++;
      if (bus.HTRANS == TN)   n_nonseq++;
      if (bus.rd_valid)       n_rdv++;
      if (bus.done)           seen_done = 1'b1;
    end
    chk1 ("t8_done_seen", seen_done, 1'b1);
    chk32("t8_beats",     32'(n_beats),  32'd256);
    chk32("t8_nonseq",    32'(n_nonseq), 32'd1);
    chk32("t8_rd_valids", 32'(n_rdv),    32'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
